cpu_top: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 51 +++++
 rtl/openmips.sv | 157 +++++++++++++++
 rtl/ram.sv | 27 ++
 rtl/regfile.sv | 36 +++
 rtl/cpu_top.sv | 37 +++
 tb/tb_cpu_top.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared encodings, widths and pipeline record types for the MIPS32 logic/shift core.
package cpu_defs_pkg;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam logic [WORD_W-1:0] NOP_INST = '0;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    alu_op_e             op;
    logic [WORD_W-1:0]   src1;
    logic [WORD_W-1:0]   src2;
    logic [REG_AW-1:0]   wd;
    logic                wreg;
  } id_ex_t;

  typedef struct packed {
    logic [REG_AW-1:0]   wd;
    logic                wreg;
    logic [WORD_W-1:0]   wdata;
  } wb_t;

  localparam id_ex_t ID_EX_NOP = '0;
  localparam wb_t    WB_NOP    = '0;

endpackage

// File: rtl/openmips.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) for the logic, shift and lui subset.
module openmips
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] inst_addr_o,
  output logic              inst_ce_o,
  input  logic [WORD_W-1:0] inst_i
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic [WORD_W-1:0] id_inst_q;
  id_ex_t            id_dec, ex_q;
  wb_t               ex_res, mem_q, wb_q;

  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs, rt, rd, sa;
  logic [15:0]       imm;
  logic [WORD_W-1:0] rf_rdata1, rf_rdata2, rs_val, rt_val;

  function automatic logic [WORD_W-1:0] alu_exec(input alu_op_e aop,
                                                  input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
    logic [4:0] sh;
    sh = a[4:0];
    case (aop)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_SLL: return b << sh;
      ALU_SRL: return b >> sh;
      ALU_SRA: return $unsigned($signed(b) >>> sh);
      ALU_LUI: return b;
      default: return '0;
    endcase
  endfunction

  // EX result wins over MEM result, which wins over the (write-through) register file
  function automatic logic [WORD_W-1:0] fwd(input logic [REG_AW-1:0] a,
                                             input logic [WORD_W-1:0] rf_val,
                                             input wb_t ex, input wb_t mem);
    if (a == REG_ZERO)                  return '0;
    else if (ex.wreg && ex.wd == a)     return ex.wdata;
    else if (mem.wreg && mem.wd == a)   return mem.wdata;
    else                                return rf_val;
  endfunction

  // IF: fetch enable rises one cycle after reset release, then pc advances every cycle
  always_comb begin
    ce_d = 1'b1;
    pc_d = ce_q ? pc_q + 32'd4 : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ce_q      <= 1'b0;
      id_inst_q <= NOP_INST;
    end else begin
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      id_inst_q <= inst_i;
    end
  end

  assign inst_addr_o = pc_q;
  assign inst_ce_o   = ce_q;

  // ID: field split, operand read with forwarding, decode
  assign op    = id_inst_q[31:26];
  assign rs    = id_inst_q[25:21];
  assign rt    = id_inst_q[20:16];
  assign rd    = id_inst_q[15:11];
  assign sa    = id_inst_q[10:6];
  assign funct = id_inst_q[5:0];
  assign imm   = id_inst_q[15:0];

  regfile regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_q.wreg),
    .waddr_i  (wb_q.wd),
    .wdata_i  (wb_q.wdata),
    .raddr1_i (rs),
    .rdata1_o (rf_rdata1),
    .raddr2_i (rt),
    .rdata2_o (rf_rdata2)
  );

  assign rs_val = fwd(rs, rf_rdata1, ex_res, mem_q);
  assign rt_val = fwd(rt, rf_rdata2, ex_res, mem_q);

  always_comb begin
    id_dec = ID_EX_NOP;
    case (op)
      OP_SPECIAL: begin
        id_dec.src1 = rs_val;
        id_dec.src2 = rt_val;
        id_dec.wd   = rd;
        case (funct)
          FN_AND:  id_dec.op = ALU_AND;
          FN_OR:   id_dec.op = ALU_OR;
          FN_XOR:  id_dec.op = ALU_XOR;
          FN_NOR:  id_dec.op = ALU_NOR;
          FN_SLL:  begin id_dec.op = ALU_SLL; id_dec.src1 = {27'b0, sa}; end
          FN_SRL:  begin id_dec.op = ALU_SRL; id_dec.src1 = {27'b0, sa}; end
          FN_SRA:  begin id_dec.op = ALU_SRA; id_dec.src1 = {27'b0, sa}; end
          FN_SLLV: id_dec.op = ALU_SLL;
          FN_SRLV: id_dec.op = ALU_SRL;
          FN_SRAV: id_dec.op = ALU_SRA;
          FN_SYNC: id_dec.op = ALU_NOP;
          default: id_dec.op = ALU_NOP;
        endcase
        id_dec.wreg = (id_dec.op != ALU_NOP);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        id_dec.src1 = rs_val;
        id_dec.src2 = {16'h0, imm};
        id_dec.wd   = rt;
        id_dec.wreg = 1'b1;
        id_dec.op   = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
      end
      OP_LUI: begin
        id_dec.src2 = {imm, 16'h0};
        id_dec.wd   = rt;
        id_dec.wreg = 1'b1;
        id_dec.op   = ALU_LUI;
      end
      OP_PREF: id_dec = ID_EX_NOP;
      default: id_dec = ID_EX_NOP;
    endcase
  end

  // EX: ALU
  always_comb begin
    ex_res.wd    = ex_q.wd;
    ex_res.wreg  = ex_q.wreg;
    ex_res.wdata = alu_exec(ex_q.op, ex_q.src1, ex_q.src2);
  end

  // ID/EX, EX/MEM and MEM/WB registers; MEM is a plain pass-through for this subset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= ID_EX_NOP;
      mem_q <= WB_NOP;
      wb_q  <= WB_NOP;
    end else begin
      ex_q  <= id_dec;
      mem_q <= ex_res;
      wb_q  <= mem_q;
    end
  end

endmodule

// File: rtl/ram.sv
// Word-addressed instruction memory with combinational read; the write port serves loaders only.
module ram
  import cpu_defs_pkg::*;
#(
  parameter int IMEM_WORDS = 128,
  parameter int IMEM_AW    = 7
) (
  input  logic               clk,
  input  logic               ce_i,
  input  logic [WORD_W-1:0]  addr_i,
  output logic [WORD_W-1:0]  inst_o,
  input  logic               we_i,
  input  logic [IMEM_AW-1:0] waddr_i,
  input  logic [WORD_W-1:0]  wdata_i
);

  logic [WORD_W-1:0] memory [0:IMEM_WORDS-1];
  logic              unused_addr_bits;

  always @(posedge clk) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  assign inst_o = ce_i ? memory[addr_i[IMEM_AW+1:2]] : '0;
  assign unused_addr_bits = ^{addr_i[WORD_W-1:IMEM_AW+2], addr_i[1:0]};

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-through, one write port.
module regfile
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [WORD_W-1:0] rdata1_o,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [WORD_W-1:0] rdata2_o
);

  logic [WORD_W-1:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [WORD_W-1:0] read_port(input logic [REG_AW-1:0] a,
                                                   input logic [WORD_W-1:0] stored);
    if (a == REG_ZERO)                 return '0;
    else if (we_i && (waddr_i == a))   return wdata_i;
    else                               return stored;
  endfunction

  assign rdata1_o = read_port(raddr1_i, regs[raddr1_i]);
  assign rdata2_o = read_port(raddr2_i, regs[raddr2_i]);

endmodule

// File: rtl/cpu_top.sv
// Simulation top: openmips core fetching from the instruction memory.
module cpu_top
  import cpu_defs_pkg::*;
#(
  parameter int IMEM_WORDS = 128,
  parameter int IMEM_AW    = 7
) (
  input logic clk,
  input logic rst
);

  logic [WORD_W-1:0] inst_addr;
  logic              inst_ce;
  logic [WORD_W-1:0] inst;

  openmips openmips (
    .clk         (clk),
    .rst         (rst),
    .inst_addr_o (inst_addr),
    .inst_ce_o   (inst_ce),
    .inst_i      (inst)
  );

  ram #(
    .IMEM_WORDS (IMEM_WORDS),
    .IMEM_AW    (IMEM_AW)
  ) ram (
    .clk     (clk),
    .ce_i    (inst_ce),
    .addr_i  (inst_addr),
    .inst_o  (inst),
    .we_i    (1'b0),
    .waddr_i ('0),
    .wdata_i ('0)
  );

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: ISA-level model with timed commits plus hand-computed register checkpoints.
module tb_cpu_top;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_top dut (.clk(clk), .rst(rst));

  int vectors = 0;
  int miscompares = 0;
  int cur;

  logic [31:0] prog [0:127];
  logic [31:0] fin  [0:31];

  // model state: sequential architectural view plus the view visible after WB latency
  logic [31:0] m_arch [0:31];
  logic [31:0] m_vis  [0:31];
  logic [31:0] m_pc;
  logic        m_ce;
  int          m_cyc = 0;
  bit          m_valid = 0;
  typedef struct { int due; logic [4:0] rd; logic [31:0] val; } pend_t;
  pend_t pend[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] shr_fill(input logic [31:0] v, input int s, input bit arith);
    logic [31:0] r;
    r = v >> s;
    if (arith && v[31]) r = r | ~(32'hFFFF_FFFF >> s);
    return r;
  endfunction

  task automatic isa_step(input logic [31:0] w);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, res;
    bit          wr;
    int          sa, sv;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
    sa = int'(w[10:6]); fn = w[5:0];
    a = m_arch[rs]; b = m_arch[rt]; sv = int'(a[4:0]);
    wr = 1; dst = rt; res = 0;
    if (op == 6'h00) begin
      dst = rd;
      case (fn)
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h00: res = b << sa;
        6'h02: res = shr_fill(b, sa, 0);
        6'h03: res = shr_fill(b, sa, 1);
        6'h04: res = b << sv;
        6'h06: res = shr_fill(b, sv, 0);
        6'h07: res = shr_fill(b, sv, 1);
        default: wr = 0;
      endcase
    end else if (op == 6'h0C) res = a & {16'h0, w[15:0]};
    else if (op == 6'h0D)     res = a | {16'h0, w[15:0]};
    else if (op == 6'h0E)     res = a ^ {16'h0, w[15:0]};
    else if (op == 6'h0F)     res = {w[15:0], 16'h0};
    else wr = 0;
    if (wr && dst != 0) begin
      m_arch[dst] = res;
      pend.push_back('{m_cyc + 4, dst, res});
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_cyc++;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_arch[i] = 0; m_vis[i] = 0; end
      pend.delete();
      m_pc = 0; m_ce = 0; m_valid = 1;
    end else if (m_valid) begin
      while (pend.size() > 0 && pend[0].due == m_cyc) begin
        m_vis[pend[0].rd] = pend[0].val;
        void'(pend.pop_front());
      end
      if (m_ce) begin
        isa_step(prog[m_pc[8:2]]);
        m_pc = m_pc + 4;
      end else m_ce = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      for (int i = 0; i < 32; i++)
        chk($sformatf("model_r%0d", i), dut.openmips.regfile.regs[i], m_vis[i]);
      chk("model_pc", dut.inst_addr, m_pc);
      chk("model_ce", {31'b0, dut.inst_ce}, {31'b0, m_ce});
    end
  end

  task automatic release_rst();
    rst = 1'b0;
    cur = -1;
  endtask

  task automatic advance(input int k);
    repeat (k - cur) @(posedge clk);
    cur = k;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rg(input int i);
    return dut.openmips.regfile.regs[i];
  endfunction

  task automatic final_checks(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), rg(i), fin[i]);
    chk({tag, "_pc"}, dut.inst_addr, 32'd160);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    prog[0]  = 32'h3C020404; // lui  $2,0x0404
    prog[1]  = 32'h34420404; // ori  $2,$2,0x0404
    prog[2]  = 32'h34070007; // ori  $7,$0,7
    prog[3]  = 32'h34050005; // ori  $5,$0,5
    prog[4]  = 32'h34080008; // ori  $8,$0,8
    prog[5]  = 32'h00021200; // sll  $2,$2,8
    prog[6]  = 32'h00E21004; // sllv $2,$2,$7
    prog[7]  = 32'h00021203; // sra  $2,$2,8
    prog[8]  = 32'h00A21007; // srav $2,$2,$5
    prog[9]  = 32'h3C038000; // lui  $3,0x8000
    prog[10] = 32'h00032103; // sra  $4,$3,4
    prog[11] = 32'h00032102; // srl  $4,$3,4
    prog[12] = 32'h01032006; // srlv $4,$3,$8
    prog[13] = 32'h00033000; // sll  $6,$3,0
    prog[14] = 32'h0000000F; // sync
    prog[15] = 32'hCC4A0010; // pref
    prog[16] = 32'h00000000; // all-zero word
    prog[17] = 32'h20090011; // addi (unsupported)
    prog[18] = 32'h00434820; // add  (unsupported funct)
    prog[19] = 32'h3400FFFF; // ori  $0,$0,0xFFFF
    prog[20] = 32'h00006027; // nor  $12,$0,$0
    prog[21] = 32'h00434825; // or   $9,$2,$3
    prog[22] = 32'h01225024; // and  $10,$9,$2
    prog[23] = 32'h01235826; // xor  $11,$9,$3
    prog[24] = 32'h318D8001; // andi $13,$12,0x8001
    prog[25] = 32'h398EFFFF; // xori $14,$12,0xFFFF
    for (int i = 0; i < 128; i++) dut.ram.memory[i] = prog[i];

    for (int i = 0; i < 32; i++) fin[i] = 32'h0;
    fin[2] = 32'h00001010; fin[3] = 32'h80000000; fin[4] = 32'h00800000;
    fin[5] = 32'h5;        fin[6] = 32'h80000000; fin[7] = 32'h7;
    fin[8] = 32'h8;        fin[9] = 32'h80001010; fin[10] = 32'h00001010;
    fin[11] = 32'h00001010; fin[12] = 32'hFFFFFFFF; fin[13] = 32'h00008001;
    fin[14] = 32'hFFFF0000;

    repeat (10) @(negedge clk);
    chk("rst_pc", dut.inst_addr, 32'h0);
    chk("rst_ce", {31'b0, dut.inst_ce}, 32'h0);
    chk("rst_r2", rg(2), 32'h0);

    release_rst();
    advance(0);  chk("first_ce", {31'b0, dut.inst_ce}, 32'h1); chk("first_pc", dut.inst_addr, 32'h0);
    advance(1);  chk("pc_step", dut.inst_addr, 32'h4);
    advance(5);  chk("lui_r2", rg(2), 32'h04040000);
    advance(6);  chk("ori_fwd_r2", rg(2), 32'h04040404);
    advance(10); chk("sll_r2", rg(2), 32'h04040400);
    advance(11); chk("sllv_r2", rg(2), 32'h02020000);
    advance(12); chk("sra_r2", rg(2), 32'h00020200);
    advance(13); chk("srav_r2", rg(2), 32'h00001010);
    advance(15); chk("sra_fill_r4", rg(4), 32'hF8000000);
    advance(16); chk("srl_r4", rg(4), 32'h08000000);
    advance(17); chk("srlv_r4", rg(4), 32'h00800000);
    advance(18); chk("sh0_r6", rg(6), 32'h80000000);
    advance(40); final_checks("run1");

    rst = 1'b1;
    repeat (3) @(negedge clk);
    release_rst();
    advance(11); chk("pre_squash_r2", rg(2), 32'h02020000);
    rst = 1'b1;
    @(negedge clk);
    chk("squash_r2", rg(2), 32'h0);
    chk("squash_r7", rg(7), 32'h0);
    chk("squash_pc", dut.inst_addr, 32'h0);
    chk("squash_ce", {31'b0, dut.inst_ce}, 32'h0);
    release_rst();
    advance(13); chk("rerun_srav_r2", rg(2), 32'h00001010);
    advance(40); final_checks("run2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
